// File: rtl/arb_rr_3.sv
// Round-robin arbiter for three packet requesters sharing one 3:1 mux and one
// downstream valid/ready stream; grant locks until last beat or stall timeout.
module arb_rr_3 #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,
  input  logic [2:0]            req_valid_i,
  input  logic [2:0]            req_last_i,
  input  logic [DATA_WIDTH-1:0] req_data_0_i,
  input  logic [DATA_WIDTH-1:0] req_data_1_i,
  input  logic [DATA_WIDTH-1:0] req_data_2_i,
  output logic [2:0]            req_ready_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            select_o,
  output logic [2:0]            grant_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_nxt;
  logic [1:0]       g, g_nxt, ptr, ptr_nxt;
  logic [1:0]       cand1, cand2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       grant, grant_nxt;
  logic             tmo_nxt;
  logic             g_vld, g_lst, tmo_hit;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic pick(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  always_comb begin
    g_vld   = pick(req_valid_i, g);
    g_lst   = pick(req_last_i, g);
    // A stall only counts toward release when the granted source has gone quiet.
    tmo_hit = (TIMEOUT > 0) && !g_vld && (cnt == CNT_HIT);
    cand1   = inc3(ptr);
    cand2   = inc3(cand1);
  end

  always_comb begin
    case (g)
      2'd0:    m_data_o = req_data_0_i;
      2'd1:    m_data_o = req_data_1_i;
      default: m_data_o = req_data_2_i;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    g_nxt       = g;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    tmo_nxt     = 1'b0;
    m_valid_o   = 1'b0;
    m_last_o    = 1'b0;
    req_ready_o = 3'b000;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|req_valid_i) begin
          if (pick(req_valid_i, ptr))        g_nxt = ptr;
          else if (pick(req_valid_i, cand1)) g_nxt = cand1;
          else                               g_nxt = cand2;
          state_nxt = LOCK;
          grant_nxt = onehot(g_nxt);
        end
      end
      default: begin
        m_valid_o   = g_vld;
        m_last_o    = g_lst;
        req_ready_o = onehot(g) & {3{m_ready_i}};
        if (g_vld && m_ready_i && g_lst) begin
          state_nxt = IDLE;
          ptr_nxt   = inc3(g);
          cnt_nxt   = '0;
          grant_nxt = 3'b000;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          ptr_nxt   = inc3(g);
          cnt_nxt   = '0;
          grant_nxt = 3'b000;
          tmo_nxt   = 1'b1;
        end else if (g_vld) begin
          cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state     <= IDLE;
      g         <= 2'd0;
      ptr       <= 2'd0;
      cnt       <= '0;
      grant     <= 3'b000;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      timeout_o <= tmo_nxt;
    end
  end

  assign select_o = g;
  assign grant_o  = grant;
  assign busy_o   = (state == LOCK);

endmodule

// File: tb/tb_arb_rr_3.sv
// Bench for arb_rr_3: a cycle table of inputs and expected outputs fed through a
// scoreboard queue, plus a hand-written stall-timeout latency sequence.
module tb_arb_rr_3;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid, req_last, req_ready, grant;
  logic [DW-1:0] d0, d1, d2, m_data;
  logic          m_valid, m_last, m_ready, busy, tmo;
  logic [1:0]    sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arb_rr_3 #(.DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk_i(clk), .s_rst_i(rst),
    .req_valid_i(req_valid), .req_last_i(req_last),
    .req_data_0_i(d0), .req_data_1_i(d1), .req_data_2_i(d2),
    .req_ready_o(req_ready), .m_valid_o(m_valid), .m_last_o(m_last),
    .m_data_o(m_data), .m_ready_i(m_ready),
    .select_o(sel), .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );

  typedef struct {
    logic          rst;
    logic [2:0]    vld;
    logic [2:0]    lst;
    logic          mrdy;
    logic [2:0]    grant;
    logic [1:0]    sel;
    logic          busy;
    logic          tmo;
    logic          mv;
    logic          ml;
    logic [2:0]    rdy;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [2:0] l,
                              input logic mr, input logic [2:0] gr, input logic [1:0] s,
                              input logic b, input logic t, input logic mv,
                              input logic ml, input logic [2:0] rd);
    vec_t x;
    x.rst = r; x.vld = v; x.lst = l; x.mrdy = mr; x.grant = gr; x.sel = s;
    x.busy = b; x.tmo = t; x.mv = mv; x.ml = ml; x.rdy = rd; x.data = '0;
    return x;
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   n;
    //              rst vld     lst     mr  grant   s  b  t  mv ml rdy
    vecs.push_back(mk(1, 3'b111, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 0, 1, 0, 1, 0, 3'b001));
    vecs.push_back(mk(0, 3'b111, 3'b001, 1, 3'b001, 0, 1, 0, 1, 1, 3'b001));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b010, 1, 1, 0, 1, 0, 3'b010));
    vecs.push_back(mk(0, 3'b111, 3'b010, 1, 3'b010, 1, 1, 0, 1, 1, 3'b010));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b100, 2, 1, 0, 1, 0, 3'b100));
    vecs.push_back(mk(0, 3'b111, 3'b100, 1, 3'b100, 2, 1, 0, 1, 1, 3'b100));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 2, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 0, 1, 0, 1, 0, 3'b001));
    vecs.push_back(mk(0, 3'b111, 3'b001, 1, 3'b001, 0, 1, 0, 1, 1, 3'b001));
    // requester 1 held off by backpressure for five cycles
    vecs.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 3'b010, 3'b000, 0, 3'b010, 1, 1, 0, 1, 0, 3'b000));
    vecs.push_back(mk(0, 3'b010, 3'b010, 1, 3'b010, 1, 1, 0, 1, 1, 3'b010));
    // requester 2 sends one beat then goes quiet until forced release
    vecs.push_back(mk(0, 3'b100, 3'b000, 1, 3'b000, 1, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b100, 3'b000, 1, 3'b100, 2, 1, 0, 1, 0, 3'b100));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 3'b000, 3'b000, 1, 3'b100, 2, 1, 0, 0, 0, 3'b100));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 2, 0, 1, 0, 0, 3'b000));
    // requester 0 locked while 1 and 2 wait
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 0, 1, 0, 1, 0, 3'b001));
    vecs.push_back(mk(0, 3'b111, 3'b000, 0, 3'b001, 0, 1, 0, 1, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b001, 1, 3'b001, 0, 1, 0, 1, 1, 3'b001));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b111, 3'b000, 1, 3'b010, 1, 1, 0, 1, 0, 3'b010));
    // reset on beat 2 of requester 1's packet
    vecs.push_back(mk(1, 3'b111, 3'b000, 1, 3'b010, 1, 1, 0, 1, 0, 3'b010));
    vecs.push_back(mk(0, 3'b011, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b011, 3'b000, 1, 3'b001, 0, 1, 0, 1, 0, 3'b001));

    @(negedge clk);
    rst = 1'b1; req_valid = 3'b111; req_last = 3'b000; m_ready = 1'b1;
    d0 = '0; d1 = '0; d2 = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      req_valid = vecs[i].vld;
      req_last  = vecs[i].lst;
      m_ready   = vecs[i].mrdy;
      d0 = 8'h10 + 8'(i);
      d1 = 8'h50 + 8'(i);
      d2 = 8'h90 + 8'(i);
      e = vecs[i];
      e.data = (e.sel == 2'd0) ? d0 : (e.sel == 2'd1) ? d1 : d2;
      sb_q.push_back(e);
      #2;
      e = sb_q.pop_front();
      check("grant_o",     i, 32'(grant),     32'(e.grant));
      check("select_o",    i, 32'(sel),       32'(e.sel));
      check("busy_o",      i, 32'(busy),      32'(e.busy));
      check("timeout_o",   i, 32'(tmo),       32'(e.tmo));
      check("m_valid_o",   i, 32'(m_valid),   32'(e.mv));
      check("m_last_o",    i, 32'(m_last),    32'(e.ml));
      check("req_ready_o", i, 32'(req_ready), 32'(e.rdy));
      if (e.mv) check("m_data_o", i, 32'(m_data), 32'(e.data));
    end

    // Requester 0 is now locked; it never raises valid again, so the pulse
    // must arrive exactly four cycles after the first quiet cycle.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #2;
      if (tmo) break;
      n++;
    end
    check("timeout_latency", n, 32'(n), 32'd4);
    @(negedge clk);
    #2;
    check("timeout_single_pulse", 0, 32'(tmo),  32'd0);
    check("idle_after_timeout",   0, 32'(busy), 32'd0);
    check("ptr_after_timeout",    0, 32'(sel),  32'd0);
    @(negedge clk);
    req_valid = 3'b111;
    @(negedge clk);
    #2;
    check("grant_after_wrap", 0, 32'(grant), 32'(3'b010));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_rr_3.md
# arb_rr_3

Round-robin packet arbiter that shares one 3-input datapath mux (select encoding 0/1/2) and one downstream valid/ready stream between three requesters. It grants one requester at a time and drives the mux select. The grant stays locked to that requester until its last beat is accepted or a stall timeout expires. It sits directly in front of the 3-way mux and downstream consumer, and generates the select and handshakes around them.

## Interface
- DATA_WIDTH, 8, width of each requester data word and of m_data_o
- TIMEOUT, 16, consecutive stalled cycles (granted valid low) before forced release; 0 disables the timeout
- clk_i  in  1  clock, all logic on rising edge
- s_rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  3  per-requester valid, bit n = requester n
- req_last_i  in  3  per-requester last-beat flag, qualified by valid
- req_data_0_i / req_data_1_i / req_data_2_i  in  DATA_WIDTH  requester data
- req_ready_o  out  3  per-requester ready, at most one bit set
- m_valid_o  out  1  downstream valid
- m_last_o  out  1  downstream last
- m_data_o  out  DATA_WIDTH  downstream data, selected by select_o
- m_ready_i  in  1  downstream ready
- select_o  out  2  mux select / granted index, registered, values 0..2 only
- grant_o  out  3  one-hot grant, registered, 0 when idle
- busy_o  out  1  high in LOCK state
- timeout_o  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, LOCK. Registers: state, grant index g, priority pointer ptr (0..2), stall counter.
- IDLE: if any req_valid_i is set, grant the first set bit in order ptr, ptr+1, ptr+2 (mod 3) and go to LOCK. If none is set, stay. select_o holds the last granted index.
- LOCK:
  - m_valid_o = req_valid_i[g], m_last_o = req_last_i[g], m_data_o = data of g.
  - req_ready_o[g] = m_ready_i; other ready bits are 0.
  - A beat is accepted when m_valid_o && m_ready_i.
- Accepted beat with last: next state IDLE, ptr <= (g+1) mod 3 (2 wraps to 0), stall counter cleared.
- Timeout (TIMEOUT>0):
  - The counter increments each LOCK cycle with req_valid_i[g]=0 and clears on any cycle with req_valid_i[g]=1.
  - When the counter equals TIMEOUT-1 and req_valid_i[g]=0: next state IDLE, ptr <= (g+1) mod 3, and timeout_o is asserted in the following cycle.
  - Counter width is $clog2(TIMEOUT+1), and it saturates.
- Last and timeout cannot coincide because timeout requires valid low.
- Requests from non-granted requesters are ignored in LOCK and are never dropped from consideration; they are re-evaluated in IDLE.
- In IDLE: m_valid_o=0, m_last_o=0, req_ready_o=0, m_data_o = data of select_o (don't care).

## Timing
- Reset values: state IDLE, ptr 0, g 0, select_o 0, grant_o 0, busy_o 0, timeout_o 0, stall counter 0. Combinational outputs m_valid_o, m_last_o and req_ready_o are therefore 0.
- Reset mid-packet abandons the packet with no timeout pulse; the next arbitration starts from ptr 0.
- Arbitration latency: a request seen in IDLE at cycle n gives LOCK, grant_o and select_o at n+1. The first beat can transfer at n+1.
- Data/valid/last/ready path is combinational through the mux with zero latency.
- After the last beat is accepted at cycle k, the block is IDLE at k+1 and the earliest next grant is at k+2. This is one mandatory dead cycle.
- Timeout: with the granted valid low from cycle t, the release edge is at the end of cycle t+TIMEOUT-1. At t+TIMEOUT the block is IDLE with timeout_o=1 for one cycle.

## Test plan
- Reset: assert s_rst_i for 2 cycles with all req_valid_i=3'b111 -> all outputs 0 during reset. The first grant after release is requester 0 (grant_o=3'b001, select_o=0).
- Round-robin: all three requesters send 2-beat packets continuously with m_ready_i=1 -> grant sequence 0,1,2,0 with select_o 0,1,2,0. One idle cycle between packets; data is passed through unchanged.
- Backpressure: granted requester 1 valid with m_ready_i low for 5 cycles -> req_ready_o=0, m_valid_o=1 and data held. Grant stays 3'b010, and no timeout occurs because valid is high.
- Timeout: TIMEOUT=4, requester 2 sends 1 non-last beat then drops valid -> release 4 cycles later. timeout_o pulses once, and the next grant goes to requester 0 (ptr wrap).
- Lock fairness: requester 0 packet in progress while requesters 1 and 2 raise valid -> req_ready_o bits 1 and 2 stay 0 until requester 0's last beat is accepted, then requester 1 is granted.
- Reset mid-packet: s_rst_i during beat 2 of 4 from requester 1 -> IDLE, grant_o=0, ptr=0. A subsequent request from requesters 0 and 1 grants 0.
